// File: rtl/and3_selftest_pkg.sv
// rtl/and3_selftest_pkg.sv - shared types and constants for the 3-input AND self-test sequencer
package and3_selftest_pkg;

  localparam int NUM_VEC = 8;
  localparam int VEC_W   = 3;
  localparam int HOLD_W  = 8;
  localparam int ERR_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/and3_vec_gen.sv
// rtl/and3_vec_gen.sv - test vector and hold-cycle counters with clear/step controls
module and3_vec_gen
  import and3_selftest_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              step_hold,
  input  logic              step_vec,
  output logic [VEC_W-1:0]  vec,
  output logic [HOLD_W-1:0] hold_cnt
);

  // Stepping the vector restarts the hold window for the new vector.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vec      <= '0;
      hold_cnt <= '0;
    end else if (step_vec) begin
      vec      <= vec + 1'b1;
      hold_cnt <= '0;
    end else if (step_hold) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/and3_selftest.sv
// rtl/and3_selftest.sv - exhaustive self-test of a 3-input AND; AND3_SELFTEST_STOP_ON_ERR_EN ends a pass on the first mismatch
module and3_selftest
  import and3_selftest_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_d,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [VEC_W-1:0] first_err_vec
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [VEC_W-1:0]  LAST_VEC  = VEC_W'(NUM_VEC - 1);

  state_t              state;
  logic [VEC_W-1:0]    vec;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                start_ok;
  logic                mismatch;
  logic                stop_now;
  logic                step_hold;
  logic                step_vec;

  assign busy      = (state == ST_DRIVE) || (state == ST_SAMPLE);
  assign {a, b, c} = busy ? vec : '0;
  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign mismatch  = (state == ST_SAMPLE) && (dut_d != (&vec));

`ifdef AND3_SELFTEST_STOP_ON_ERR_EN
  assign stop_now = (vec == LAST_VEC) || mismatch;
`else
  assign stop_now = (vec == LAST_VEC);
`endif

  assign step_hold = (state == ST_DRIVE);
  assign step_vec  = (state == ST_SAMPLE) && !stop_now;

  and3_vec_gen u_vec_gen (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_ok),
    .step_hold (step_hold),
    .step_vec  (step_vec),
    .vec       (vec),
    .hold_cnt  (hold_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      first_err_vec <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_vec <= '0;
            state         <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (hold_cnt == HOLD_LAST) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            err_cnt <= err_cnt + 1'b1;
            if (err_cnt == '0) first_err_vec <= vec;
          end
          state <= stop_now ? ST_DONE : ST_DRIVE;
        end
        default: begin
          if (start_ok) begin
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_vec <= '0;
            state         <= ST_DRIVE;
          end else begin
            // Result flags settle on the first DONE cycle, once err_cnt is final.
            done <= 1'b1;
            pass <= (err_cnt == '0);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_and3_selftest.sv
// tb/tb_and3_selftest.sv - scoreboard bench for and3_selftest
module tb_and3_selftest;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start1;
  logic       sel;
  int         mode;

  logic       a4, b4, c4, busy4, done4, pass4, d4;
  logic [3:0] err4;
  logic [2:0] first4;
  logic       a1, b1, c1, busy1, done1, pass1, d1;
  logic [3:0] err1;
  logic [2:0] first1;

  logic [2:0] abc_s, first_s;
  logic [3:0] err_s;
  logic       busy_s, done_s, pass_s;

  typedef struct {
    int edges;
    int pass;
    int err;
    int first;
  } exp_t;

  exp_t exp_q[$];
  int   vec_q[$];
  int   obs_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic prev_busy = 1'b0;
  logic [2:0] prev_abc = 3'b000;

  always #5 clk = ~clk;

  // mode 0: golden AND, 1: stuck-at-1, 2: output forced low on 111
  function automatic logic model_d(input int m, input logic [2:0] v);
    case (m)
      1:       return 1'b1;
      2:       return (v == 3'd7) ? 1'b0 : &v;
      default: return &v;
    endcase
  endfunction

  assign d4 = model_d(mode, {a4, b4, c4});
  assign d1 = model_d(mode, {a1, b1, c1});

  and3_selftest #(.HOLD_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .dut_d(d4),
    .a(a4), .b(b4), .c(c4), .busy(busy4), .done(done4), .pass(pass4),
    .err_cnt(err4), .first_err_vec(first4)
  );

  and3_selftest #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .dut_d(d1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .first_err_vec(first1)
  );

  assign abc_s   = sel ? {a1, b1, c1} : {a4, b4, c4};
  assign busy_s  = sel ? busy1  : busy4;
  assign done_s  = sel ? done1  : done4;
  assign pass_s  = sel ? pass1  : pass4;
  assign err_s   = sel ? err1   : err4;
  assign first_s = sel ? first1 : first4;

  always @(negedge clk) begin
    if (busy_s && (!prev_busy || abc_s != prev_abc)) obs_q.push_back(int'(abc_s));
    prev_busy = busy_s;
    prev_abc  = abc_s;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic s);
    if (s) start1 = 1'b1;
    else   start4 = 1'b1;
  endtask

  task automatic run_pass(input logic s, input int m, input int hold, input int mid);
    exp_t       e;
    int         cnt;
    int         edges;
    logic       stop;
    logic       got_done;
    logic [2:0] vv;
    sel = s;
    mode = m;
    e.err = 0;
    e.first = 0;
    cnt = 0;
    stop = 1'b0;
    for (int v = 0; v < 8; v++) begin
      if (!stop) begin
        vv = v[2:0];
        vec_q.push_back(v);
        cnt++;
        if (model_d(m, vv) !== (&vv)) begin
          if (e.err == 0) e.first = v;
          e.err++;
`ifdef AND3_SELFTEST_STOP_ON_ERR_EN
          stop = 1'b1;
`endif
        end
      end
    end
    e.edges = cnt * (hold + 1) + 1;
    e.pass  = (e.err == 0) ? 1 : 0;
    exp_q.push_back(e);

    @(negedge clk);
    pulse_start(s);
    @(posedge clk);
    #1;
    start4 = 1'b0;
    start1 = 1'b0;
    check("busy_after_start", busy_s, 1);
    check("done_cleared", done_s, 0);
    check("err_cleared", err_s, 0);

    edges = 0;
    got_done = 1'b0;
    while (!got_done && edges < 2000) begin
      @(posedge clk);
      #1;
      start4 = 1'b0;
      start1 = 1'b0;
      edges++;
      if (done_s) got_done = 1'b1;
      else if (edges == mid) pulse_start(s);
    end

    e = exp_q.pop_front();
    check("done_edge", edges, e.edges);
    check("pass", pass_s, e.pass);
    check("err_cnt", err_s, e.err);
    if (e.err != 0) check("first_err_vec", first_s, e.first);
    check("busy_in_done", busy_s, 0);
    check("abc_in_done", abc_s, 0);
    check("vec_count", obs_q.size(), vec_q.size());
    while (obs_q.size() > 0 && vec_q.size() > 0)
      check("vec_seq", obs_q.pop_front(), vec_q.pop_front());
    obs_q.delete();
    vec_q.delete();
  endtask

  task automatic reset_mid();
    sel = 1'b0;
    mode = 1;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    // After 16 edges the H=4 unit is driving vector 3 with vectors 0..2 already failed.
    repeat (16) @(posedge clk);
    #1;
    check("pre_rst_vec", abc_s, 3);
    check("pre_rst_err", err_s, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_abc", abc_s, 0);
    check("rst_busy", busy_s, 0);
    check("rst_done", done_s, 0);
    check("rst_pass", pass_s, 0);
    check("rst_err", err_s, 0);
    check("rst_first", first_s, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_stays_idle", busy_s, 0);
    obs_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    start4 = 1'b0;
    start1 = 1'b0;
    sel = 1'b0;
    mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_abc4", {a4, b4, c4}, 0);
    check("reset_busy4", busy4, 0);
    check("reset_done4", done4, 0);
    check("reset_pass4", pass4, 0);
    check("reset_err4", err4, 0);
    check("reset_first4", first4, 0);
    check("reset_busy1", busy1, 0);
    check("reset_err1", err1, 0);
    // Start alongside reset must lose to reset.
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    check("rst_over_start", busy4, 0);
    @(negedge clk);
    rst = 1'b0;
    obs_q.delete();

    run_pass(1'b0, 0, 4, 0);
    run_pass(1'b1, 1, 1, 0);
    run_pass(1'b0, 2, 4, 0);
    reset_mid();
    run_pass(1'b0, 0, 4, 0);
    run_pass(1'b0, 0, 4, 10);
    run_pass(1'b0, 1, 4, 0);
    run_pass(1'b0, 0, 4, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
